// File: rtl/key_event.sv
// Turns a debounced key level into press/release/long/repeat events; optional auto-repeat via KEY_AUTO_RPT_EN.
// Latency: press/release events are visible one clock after data_i is sampled; long/repeat follow whole tick periods.
// Backpressure: single-entry valid/ready register; an event arriving while full and not accepted is dropped and sets ovf_o.
module key_event #(
  parameter int TICK_W  = 8,
  parameter int CNT_W   = 8,
  parameter int LONG_TK = 100,
  parameter int RPT_TK  = 20
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       data_i,
  output logic       held_o,
  output logic [1:0] evt_o,
  output logic       evt_vld_o,
  input  logic       evt_rdy_i,
  output logic       ovf_o,
  input  logic       ovf_clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam logic [1:0] EVT_PRESS = 2'd0;
  localparam logic [1:0] EVT_REL   = 2'd1;
  localparam logic [1:0] EVT_LONG  = 2'd2;
  localparam logic [1:0] EVT_RPT   = 2'd3;

`ifdef KEY_AUTO_RPT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  // Thresholds are compared for equality, truncated to the counter width.
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TK - 1);
  localparam logic [CNT_W-1:0] RPT_M1  = CNT_W'(RPT_TK - 1);

  state_t             state;
  state_t             state_nx;
  logic               d_r;
  logic [TICK_W-1:0]  pre;
  logic [CNT_W-1:0]   cnt;
  logic               rise;
  logic               fall;
  logic               tick;
  logic               new_vld;
  logic [1:0]         new_dat;
  logic               cnt_run;

  assign rise = data_i & ~d_r;
  assign fall = ~data_i & d_r;
  assign tick = &pre;

  // Hold time only accumulates while pressed; in LONG only when repeats are enabled.
  assign cnt_run = (state == PRESS) || ((state == LONG) && AUTO_RPT);

  // Next-state and event selection; release takes priority over a coincident threshold tick.
  always_comb begin
    state_nx = state;
    new_vld  = 1'b0;
    new_dat  = EVT_PRESS;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRESS;
          new_vld  = 1'b1;
          new_dat  = EVT_PRESS;
        end
      end
      PRESS: begin
        if (fall) begin
          state_nx = IDLE;
          new_vld  = 1'b1;
          new_dat  = EVT_REL;
        end else if (tick && (cnt == LONG_M1)) begin
          state_nx = LONG;
          new_vld  = 1'b1;
          new_dat  = EVT_LONG;
        end
      end
      LONG: begin
        if (fall) begin
          state_nx = IDLE;
          new_vld  = 1'b1;
          new_dat  = EVT_REL;
        end else if (AUTO_RPT && tick && (cnt == RPT_M1)) begin
          new_vld  = 1'b1;
          new_dat  = EVT_RPT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Key state, edge history, prescaler and hold-tick counter; every event restarts the hold count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      d_r    <= 1'b0;
      pre    <= '0;
      cnt    <= '0;
      held_o <= 1'b0;
    end else begin
      state  <= state_nx;
      d_r    <= data_i;
      held_o <= (state_nx != IDLE);
      pre    <= rise ? '0 : pre + TICK_W'(1);
      if (rise || new_vld) begin
        cnt <= '0;
      end else if (tick && cnt_run) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Single-entry output register: load when empty or draining, otherwise drop and flag overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      evt_o     <= EVT_PRESS;
      evt_vld_o <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      if (new_vld) begin
        if (!evt_vld_o || evt_rdy_i) begin
          evt_o     <= new_dat;
          evt_vld_o <= 1'b1;
        end
      end else if (evt_vld_o && evt_rdy_i) begin
        evt_vld_o <= 1'b0;
      end
      if (new_vld && evt_vld_o && !evt_rdy_i) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with TICK_W=4, LONG_TK=8, RPT_TK=2 (tick every 16 clocks).
// Event times are counted in clocks from the clock edge that first samples the key high.
// Expectations follow KEY_AUTO_RPT_EN when the bench is compiled with it.
module tb_key_event;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       data = 1'b0;
  logic       held;
  logic [1:0] evt;
  logic       evt_vld;
  logic       evt_rdy = 1'b1;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int base   = 0;
  int held_cnt = 0;
  int ev_code[$];
  int ev_time[$];
  int exp_c[8];
  int exp_t[8];

  key_event #(
    .TICK_W (4),
    .CNT_W  (8),
    .LONG_TK(8),
    .RPT_TK (2)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .data_i   (data),
    .held_o   (held),
    .evt_o    (evt),
    .evt_vld_o(evt_vld),
    .evt_rdy_i(evt_rdy),
    .ovf_o    (ovf),
    .ovf_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log accepted events and held time, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_vld && evt_rdy) begin
        ev_code.push_back(int'(evt));
        ev_time.push_back(cyc - base);
      end
      if (held) held_cnt = held_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_log();
    ev_code.delete();
    ev_time.delete();
    held_cnt = 0;
    base = cyc;
  endtask

  task automatic chk_events(input string tag, input int n);
    chk({tag, "_count"}, ev_code.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < ev_code.size()) begin
        chk($sformatf("%s_code%0d", tag, i), ev_code[i], exp_c[i]);
        chk($sformatf("%s_time%0d", tag, i), ev_time[i], exp_t[i]);
      end
    end
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_held", held, 0);
    chk("rst_vld", evt_vld, 0);
    chk("rst_evt", evt, 0);
    chk("rst_ovf", ovf, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_vld", evt_vld, 0);

    // Short press: 50 clocks high
    start_log();
    data = 1'b1;
    repeat (50) step();
    data = 1'b0;
    repeat (5) step();
    exp_c[0] = 0; exp_t[0] = 1;
    exp_c[1] = 1; exp_t[1] = 51;
    chk_events("short", 2);
    chk("short_held", held_cnt, 50);
    repeat (10) step();

    // Long hold: 200 clocks high
    start_log();
    data = 1'b1;
    repeat (200) step();
    data = 1'b0;
    repeat (5) step();
    exp_c[0] = 0; exp_t[0] = 1;
    exp_c[1] = 2; exp_t[1] = 129;
`ifdef KEY_AUTO_RPT_EN
    exp_c[2] = 3; exp_t[2] = 161;
    exp_c[3] = 3; exp_t[3] = 193;
    exp_c[4] = 1; exp_t[4] = 201;
    chk_events("long", 5);
`else
    exp_c[2] = 1; exp_t[2] = 201;
    chk_events("long", 3);
`endif
    chk("long_held", held_cnt, 200);
    repeat (10) step();

    // Fall on the same clock as the 8th tick: release only
    start_log();
    data = 1'b1;
    repeat (128) step();
    data = 1'b0;
    repeat (5) step();
    exp_c[0] = 0; exp_t[0] = 1;
    exp_c[1] = 1; exp_t[1] = 129;
    chk_events("thresh", 2);
    repeat (10) step();

    // Backpressure: press held in register, release dropped
    evt_rdy = 1'b0;
    data = 1'b1;
    step();
    chk("bp_vld", evt_vld, 1);
    chk("bp_evt_press", evt, 0);
    repeat (9) step();
    data = 1'b0;
    chk("bp_ovf_before", ovf, 0);
    step();
    chk("bp_ovf_set", ovf, 1);
    chk("bp_evt_hold", evt, 0);
    chk("bp_vld_hold", evt_vld, 1);
    evt_rdy = 1'b1;
    step();
    chk("bp_vld_clr", evt_vld, 0);
    chk("bp_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("bp_ovf_clr", ovf, 0);
    repeat (5) step();

    // Drop and clear together: set wins
    evt_rdy = 1'b0;
    data = 1'b1;
    step();
    data = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("setwin_ovf", ovf, 1);
    evt_rdy = 1'b1;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("setwin_ovf_clr", ovf, 0);
    repeat (5) step();

    // Accept-and-load in the same cycle
    evt_rdy = 1'b0;
    data = 1'b1;
    repeat (4) step();
    chk("al_press_pending", evt_vld, 1);
    data = 1'b0;
    evt_rdy = 1'b1;
    step();
    chk("al_evt_release", evt, 1);
    chk("al_vld_stays", evt_vld, 1);
    chk("al_no_ovf", ovf, 0);
    step();
    chk("al_drained", evt_vld, 0);
    repeat (5) step();

    // Async reset in LONG with the long event still pending
    data = 1'b1;
    evt_rdy = 1'b1;
    repeat (128) step();
    evt_rdy = 1'b0;
    repeat (7) step();
    chk("ar_pre_evt_long", evt, 2);
    chk("ar_pre_vld", evt_vld, 1);
    chk("ar_pre_held", held, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_held", held, 0);
    chk("ar_vld", evt_vld, 0);
    chk("ar_evt", evt, 0);
    chk("ar_ovf", ovf, 0);
    step();
    rst_n = 1'b1;
    evt_rdy = 1'b1;
    step();
    chk("ar_repress_vld", evt_vld, 1);
    chk("ar_repress_evt", evt, 0);
    chk("ar_repress_held", held, 1);
    data = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumes the single debounced pushbutton level produced by the debounce stage.
- Converts it into discrete key events: press, release, long-press and (optionally) auto-repeat.
- Presents events through a single-entry valid/ready output register.
- Sits between the debounce stage and the UI/register-interface logic that services front-panel buttons.

Parameters:
TICK_W, 8, prescaler width; hold-time tick period = 2^TICK_W clocks (min 2)
CNT_W, 8, hold tick counter width
LONG_TK, 100, ticks from press to long event (1 .. 2^CNT_W-1)
RPT_TK, 20, ticks between repeat events after long (1 .. 2^CNT_W-1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  async. reset, active lo
data_i  in  1  debounced key level (1 = pressed), synchronous to clk_i
held_o  out  1  key currently considered held (state != IDLE)
evt_o  out  2  event code: 0 press, 1 release, 2 long, 3 repeat
evt_vld_o  out  1  event register valid
evt_rdy_i  in  1  consumer accepts event when evt_vld_o & evt_rdy_i
ovf_o  out  1  sticky: event dropped because register was occupied
ovf_clr_i  in  1  synchronous clear of ovf_o

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous and active-low (rst_n_i).
- Reset values:
  - state = IDLE; d_r (previous data_i) = 0; prescaler = 0; tick counter = 0.
  - held_o = 0; evt_o = 0; evt_vld_o = 0; ovf_o = 0.
- Edge detect: rise = data_i & ~d_r; fall = ~data_i & d_r; d_r <= data_i every clock. There is no resync; the input is already synchronous.
- If data_i is high when reset deasserts, a press event is generated on the first clock.
- Prescaler and tick counter:
  - The prescaler counts modulo 2^TICK_W and is cleared on rise.
  - tick = prescaler at all ones.
  - The tick counter increments on tick, is cleared on rise, and is cleared on every state change.
- State machine:
  - IDLE: on rise -> emit press, go to PRESS.
  - PRESS: on fall -> emit release, go to IDLE. Else on tick with counter == LONG_TK-1 -> emit long, go to LONG, counter cleared.
  - LONG: on fall -> emit release, go to IDLE. Else on tick with counter == RPT_TK-1 -> emit repeat, counter cleared, stay in LONG.
- Simultaneous fall and threshold tick: release wins; no long/repeat is emitted.
- Timing:
  - The press event is visible (evt_vld_o = 1, evt_o = 0) one clock after data_i first samples high.
  - The long event is loaded exactly LONG_TK * 2^TICK_W clocks after the press event is loaded.
  - Repeat events are spaced RPT_TK * 2^TICK_W clocks apart.
- held_o: registered; asserts with the press event and deasserts with the release event.
- Output register handshake:
  - A new event loads when the register is empty, or when it is being accepted in the same cycle (vld & rdy). In that case the new event is loaded and evt_vld_o stays 1, with no overflow.
  - A new event while vld & ~rdy is dropped: the register is unchanged and ovf_o <= 1.
  - Accept without a new event: evt_vld_o <= 0.
  - evt_o is held stable while evt_vld_o & ~evt_rdy_i.
- ovf_o: cleared by ovf_clr_i. If a drop and ovf_clr_i occur in the same cycle, set wins.
- Counter width: the tick counter never wraps. Compares are equality against parameter-1, truncated to CNT_W.
- Reset mid-hold: everything returns to reset values. No release event is emitted for the aborted hold.

Optional Feature:
KEY_AUTO_RPT_EN
- Defined: LONG state emits repeat events as described above.
- Not defined:
  - LONG state only waits for fall, then emits release.
  - The tick counter is frozen in LONG.
  - No event code 3 is ever produced.
  - RPT_TK is unused.

Test Plan:
- Short press. TICK_W=4, LONG_TK=8, RPT_TK=2, evt_rdy_i=1; data_i high 50 clocks then low:
  - press event 1 clock after rise.
  - release event 1 clock after fall.
  - no long event; held_o high for exactly 50 clocks.
- Long hold, same params, data_i high 200 clocks:
  - press at t=1, long at t=129.
  - with macro defined: repeats at t=161 and t=193, then release at t=201.
  - without macro: no repeats, release at t=201.
- Release on threshold: data_i falls on the same clock the 8th tick occurs -> release only; no long event emitted.
- Backpressure: evt_rdy_i=0, press then release 10 clocks later:
  - evt_o stays 0 (press) with evt_vld_o=1.
  - ovf_o sets 1 clock after release.
  - raising evt_rdy_i then clears evt_vld_o next clock.
  - ovf_clr_i clears ovf_o.
- Accept-and-load same cycle: with press pending, hold evt_rdy_i=1 on the exact cycle the release loads -> evt_o=1, evt_vld_o stays 1, ovf_o stays 0.
- Async reset: assert rst_n_i low mid-LONG -> all outputs go to 0 immediately (no clock needed). Deassert with data_i high -> fresh press event on the next clock.
